// File: rtl/data_memory_arbiter_if.sv
// rtl/data_memory_arbiter_if.sv - requester and data-memory signals of the two-port data memory arbiter
interface data_memory_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [DATA_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  ack0, ack1;
  logic                  err0, err1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  MemWrite, MemRead;
  logic [DATA_WIDTH-1:0] Address, WriteData, ReadData;
  logic                  busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ReadData,
    output ack0, ack1, err0, err1, rdata0, rdata1,
    output MemWrite, MemRead, Address, WriteData, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ReadData,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
    input  MemWrite, MemRead, Address, WriteData, busy
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-requester arbiter in front of a single-port data memory
// Define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests; otherwise port 0 has fixed priority.
module data_memory_arbiter #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h10010000
) (
  input  logic                  clk,
  input  logic                  reset,
  data_memory_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // One extra bit so BASE_ADDR + MEMORY_DEPTH cannot wrap at the top of the address space.
  localparam logic [DATA_WIDTH:0] RANGE_LO = (DATA_WIDTH+1)'(BASE_ADDR);
  localparam logic [DATA_WIDTH:0] RANGE_HI = RANGE_LO + (DATA_WIDTH+1)'(MEMORY_DEPTH);

  state_t                state_q, state_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  grant1;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] sel_addr;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign grant1 = bus.req1 & (~bus.req0 | ~last_q);
`else
  assign grant1 = bus.req1 & ~bus.req0;
`endif

  assign sel_addr = grant1 ? bus.addr1 : bus.addr0;
  assign in_range = ({1'b0, sel_addr} >= RANGE_LO) && ({1'b0, sel_addr} < RANGE_HI);

  always_comb begin
    state_d       = state_q;
    port_d        = port_q;
    we_d          = we_q;
    err_d         = err_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d        = last_q;
`endif
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.Address   = '0;
    bus.WriteData = '0;
    bus.ack0      = 1'b0;
    bus.ack1      = 1'b0;
    bus.err0      = 1'b0;
    bus.err1      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          port_d  = grant1;
          we_d    = grant1 ? bus.we1 : bus.we0;
          addr_d  = sel_addr;
          wdata_d = grant1 ? bus.wdata1 : bus.wdata0;
          err_d   = ~in_range;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = grant1;
`endif
          if (in_range) begin
            state_d = ACCESS;
          end else begin
            // Errored accesses skip the memory and report zero data.
            state_d = DONE;
            if (grant1) rdata1_d = '0;
            else        rdata0_d = '0;
          end
        end
      end
      ACCESS: begin
        bus.MemWrite  = we_q;
        bus.MemRead   = ~we_q;
        bus.Address   = addr_q;
        bus.WriteData = wdata_q;
        state_d       = DONE;
        if (port_q) rdata1_d = we_q ? '0 : bus.ReadData;
        else        rdata0_d = we_q ? '0 : bus.ReadData;
      end
      DONE: begin
        bus.ack0 = ~port_q;
        bus.ack1 = port_q;
        bus.err0 = err_q & ~port_q;
        bus.err1 = err_q & port_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
  assign bus.busy   = (state_q != IDLE);
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - randomized transaction-level check of data_memory_arbiter
// Build with ARB_ROUND_ROBIN_EN defined to check the alternating-grant configuration.
module tb_data_memory_arbiter;
  localparam logic [31:0] BASE  = 32'h10010000;
  localparam int          DEPTH = 1024;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  data_memory_arbiter_if #(.DATA_WIDTH(32)) bus ();

  data_memory_arbiter #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory seen by the arbiter: combinational read, write on the clock edge.
  logic [31:0] mem [256];
  assign bus.ReadData = mem[bus.Address[9:2]];
  always @(posedge clk) if (bus.MemWrite) mem[bus.Address[9:2]] <= bus.WriteData;

  // Reference model state.
  logic [31:0] ref_mem [256];
  bit          pend [2];
  bit          pwe  [2];
  logic [31:0] paddr[2];
  logic [31:0] pwd  [2];
  logic [31:0] exp_rd[2];
  bit          last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + DEPTH);
  endfunction

  function automatic bit pick_winner();
    if (pend[0] && pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
      return ~last;
`else
      return 1'b0;
`endif
    end
    return pend[1] && !pend[0];
  endfunction

  task automatic drive_reqs();
    bus.req0 = pend[0]; bus.we0 = pwe[0]; bus.addr0 = paddr[0]; bus.wdata0 = pwd[0];
    bus.req1 = pend[1]; bus.we1 = pwe[1]; bus.addr1 = paddr[1]; bus.wdata1 = pwd[1];
  endtask

  task automatic drop_req(input bit p, input bit scramble);
    if (p) begin
      bus.req1 = 1'b0;
      if (scramble) begin bus.addr1 = $urandom; bus.wdata1 = $urandom; bus.we1 = ~bus.we1; end
    end else begin
      bus.req0 = 1'b0;
      if (scramble) begin bus.addr0 = $urandom; bus.wdata0 = $urandom; bus.we0 = ~bus.we0; end
    end
  endtask

  task automatic set_pend(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d);
    pend[p] = 1'b1; pwe[p] = we; paddr[p] = a; pwd[p] = d;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      5:       return BASE + DEPTH;
      6:       return BASE - 4;
      7:       return BASE + DEPTH - 4;
      default: return BASE + 4 * $urandom_range(0, 15);
    endcase
  endfunction

  // Called in an IDLE cycle with the pending requests already driven.
  task automatic run_txn(input bit drop_early);
    bit          w, e, twe;
    logic [31:0] ta, td;
    w   = pick_winner();
    twe = pwe[w]; ta = paddr[w]; td = pwd[w];
    e   = !in_rng(ta);
    pend[w] = 1'b0;
    last    = w;
    @(posedge clk); #1;
    if (drop_early) drop_req(w, 1'b1);
    if (!e) begin
      check("acc_busy", bus.busy, 1);
      check("acc_memwrite", bus.MemWrite, twe);
      check("acc_memread", bus.MemRead, !twe);
      check("acc_address", bus.Address, ta);
      check("acc_writedata", bus.WriteData, td);
      check("acc_ack0", bus.ack0, 0);
      check("acc_ack1", bus.ack1, 0);
      @(posedge clk); #1;
    end
    exp_rd[w] = (e || twe) ? 32'h0 : ref_mem[ta[9:2]];
    if (!e && twe) ref_mem[ta[9:2]] = td;
    check("done_busy", bus.busy, 1);
    check("done_ack0", bus.ack0, w == 1'b0);
    check("done_ack1", bus.ack1, w == 1'b1);
    check("done_err0", bus.err0, (w == 1'b0) && e);
    check("done_err1", bus.err1, (w == 1'b1) && e);
    check("done_rdata0", bus.rdata0, exp_rd[0]);
    check("done_rdata1", bus.rdata1, exp_rd[1]);
    check("done_memwrite", bus.MemWrite, 0);
    check("done_memread", bus.MemRead, 0);
    check("done_address", bus.Address, 0);
    drop_req(w, 1'b0);
    @(posedge clk); #1;
    check("idle_busy", bus.busy, 0);
    check("idle_ack0", bus.ack0, 0);
    check("idle_ack1", bus.ack1, 0);
    check("idle_rdata0", bus.rdata0, exp_rd[0]);
    check("idle_rdata1", bus.rdata1, exp_rd[1]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_ack0"}, bus.ack0, 0);
    check({tag, "_ack1"}, bus.ack1, 0);
    check({tag, "_err0"}, bus.err0, 0);
    check({tag, "_err1"}, bus.err1, 0);
    check({tag, "_rdata0"}, bus.rdata0, 0);
    check({tag, "_rdata1"}, bus.rdata1, 0);
    check({tag, "_memwrite"}, bus.MemWrite, 0);
    check({tag, "_memread"}, bus.MemRead, 0);
    check({tag, "_address"}, bus.Address, 0);
    check({tag, "_writedata"}, bus.WriteData, 0);
  endtask

  task automatic model_reset();
    pend[0] = 0; pend[1] = 0;
    exp_rd[0] = 0; exp_rd[1] = 0;
    last = 1'b1;
    drive_reqs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      pwe[p] = 0; paddr[p] = '0; pwd[p] = '0;
    end
    model_reset();
    reset = 1'b0;
    #3;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Write then read back through port 0.
    set_pend(0, 1, 32'h10010004, 32'hDEADBEEF); drive_reqs(); run_txn(0);
    set_pend(0, 0, 32'h10010004, 32'h0);        drive_reqs(); run_txn(0);
    check("readback_rdata0", bus.rdata0, 32'hDEADBEEF);

    // First address past the segment.
    set_pend(1, 0, BASE + DEPTH, 32'h0); drive_reqs(); run_txn(0);
    set_pend(1, 0, BASE + DEPTH - 4, 32'h0); drive_reqs(); run_txn(0);
    set_pend(0, 1, BASE - 4, 32'h12345678); drive_reqs(); run_txn(0);

    // Both requesters held for four back-to-back transactions.
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p]) set_pend(p[0], $urandom_range(0, 1), BASE + 4 * $urandom_range(0, 15), $urandom);
      drive_reqs();
      run_txn(0);
    end
    while (pend[0] || pend[1]) begin drive_reqs(); run_txn(0); end

    // Early request drop still completes with a single ack.
    set_pend(0, 0, 32'h10010004, 32'h0); drive_reqs(); run_txn(1);

    // Reset in the middle of a write access.
    set_pend(0, 1, 32'h10010008, 32'hA5A5F00D); drive_reqs();
    pend[0] = 0;
    @(posedge clk); #1;
    check("mid_memwrite", bus.MemWrite, 1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid");
    @(posedge clk); #1;
    check("mid_mem_unchanged", mem[2], ref_mem[2]);
    check_reset_outputs("mid_hold");
    model_reset();
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ack0", bus.ack0, 0);
    check("post_rst_busy", bus.busy, 0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 1)) set_pend(p[0], $urandom_range(0, 1), rand_addr(), $urandom);
      if (!pend[0] && !pend[1]) begin
        int q;
        q = $urandom_range(0, 1);
        set_pend(q[0], $urandom_range(0, 1), rand_addr(), $urandom);
      end
      drive_reqs();
      run_txn($urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
